// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM encoding, funct3 size codes,
// default data-region limit and the alignment rule.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    HOLD  = 3'd3,
    RESP  = 3'd4
  } lsu_state_t;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  localparam logic [31:0] DATA_LIMIT_DEFAULT = 32'h0000_1000;

  // size[1:0] alone selects the access width; the top bit only picks zero-extension
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size[1:0])
      2'b00:   return 1'b0;
      2'b01:   return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

  function automatic logic is_partial(input logic [2:0] size);
    return size[1:0] == 2'b00 || size[1:0] == 2'b01;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Lane steering for a word-only memory port: extracts and extends load lanes,
// and merges a byte/halfword store into a previously read word. Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = word[{addr_lo, 3'b000} +: 8];
    half_sel   = addr_lo[1] ? word[31:16] : word[15:0];
    load_val   = word;
    store_word = wdata;

    case (size)
      SIZE_B:  load_val = {{24{byte_sel[7]}}, byte_sel};
      SIZE_BU: load_val = {24'b0, byte_sel};
      SIZE_H:  load_val = {{16{half_sel[15]}}, half_sel};
      SIZE_HU: load_val = {16'b0, half_sel};
      default: ;
    endcase

    // untouched lanes keep the bytes captured during READ
    case (size[1:0])
      2'b00: begin
        store_word = word;
        store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      2'b01: begin
        store_word = word;
        store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage sequencer to a word-only memory port; byte/half stores are read-modify-write.
// Latency accept->resp_valid: load 2, SW 3, SB/SH 4, error 1; one request in flight, resp held until resp_ready.
// LSU_ACCESS_CHECK_EN: rejects addresses >= DATA_LIMIT with resp_err and no memory access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    DATA_LIMIT = ADDR_W'(DATA_LIMIT_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       data_out
);

`ifdef LSU_ACCESS_CHECK_EN
  localparam bit ACCESS_CHECK = 1'b1;
`else
  localparam bit ACCESS_CHECK = 1'b0;
`endif

  lsu_state_t  state_q, state_d;
  logic        accept;
  logic        req_err;
  logic        we_q;
  logic [2:0]  size_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;
  logic [31:0] load_val;
  logic [31:0] store_word;

  assign req_err    = is_misaligned(req_size, req_addr[1:0]) ||
                      (ACCESS_CHECK && (req_addr >= DATA_LIMIT));
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);

  lsu_lane_align u_align (
    .addr_lo    (addr_lo_q),
    .size       (size_q),
    .word       (data_out),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (req_err)                            state_d = RESP;
          else if (!req_we || is_partial(req_size)) state_d = READ;
          else                                    state_d = WRITE;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = HOLD;
      HOLD:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // strobes are registered from the next state so the memory sees glitch-free edges
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      size_q     <= 3'b000;
      addr_lo_q  <= 2'b00;
      wdata_q    <= 32'h0;
      data_addr  <= '0;
      data_in    <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else begin
      mem_read  <= (state_d == READ);
      mem_write <= (state_d == WRITE);
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q       <= req_we;
            size_q     <= req_size;
            addr_lo_q  <= req_addr[1:0];
            wdata_q    <= req_wdata;
            resp_rdata <= 32'h0;
            resp_err   <= req_err;
            if (!req_err) begin
              data_addr <= {req_addr[ADDR_W-1:2], 2'b00};
              if (req_we && !is_partial(req_size)) data_in <= req_wdata;
            end
          end
        end
        READ: begin
          if (we_q) data_in    <= store_word;
          else      resp_rdata <= load_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: word memory model on the data port,
// table-driven requests with a response scoreboard, plus backpressure and mid-operation reset sequences.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] data_out;

  logic [31:0] mem [0:2047];
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[15];

  load_store_unit #(.ADDR_W(32), .DATA_LIMIT(32'h1000)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .data_addr  (data_addr),
    .data_in    (data_in),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  assign data_out = mem[data_addr[12:2]];

  // memory commits shortly after the mem_write rising edge
  always @(posedge mem_write) begin
    #1;
    mem[data_addr[12:2]] = data_in;
    wr_cnt++;
  end

  always @(negedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_read && mem_write) both_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v, input int hold);
    exp_t e;
    exp_t got;
    int   lat;
    sb.push_back('{v.exp_rdata, v.exp_err, v.exp_lat, v.exp_rd, v.exp_wr});
    @(negedge clk);
    chk("ready_before_req", {31'b0, req_ready}, 32'd1);
    rd_cnt    = 0;
    wr_cnt    = 0;
    req_valid = 1'b1;
    req_we    = v.we;
    req_size  = v.size;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    for (int h = 0; h < hold; h++) begin
      chk("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    got.rdata = resp_rdata;
    got.err   = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    got.lat = lat;
    got.rd  = rd_cnt;
    got.wr  = wr_cnt;
    e = sb.pop_front();
    chk($sformatf("rdata@%h", v.addr), got.rdata, e.rdata);
    chk($sformatf("err@%h", v.addr), {31'b0, got.err}, {31'b0, e.err});
    chk($sformatf("latency@%h", v.addr), got.lat, e.lat);
    chk($sformatf("reads@%h", v.addr), got.rd, e.rd);
    chk($sformatf("writes@%h", v.addr), got.wr, e.wr);
    chk("resp_dropped", {31'b0, resp_valid}, 32'd0);
    chk("ready_after_resp", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem[4]     = 32'h8899AABB;
    mem[5]     = 32'h11223344;
    mem[8]     = 32'h00000000;
    mem[9]     = 32'hCAFEF00D;
    mem[11'h400] = 32'h12345678;

    vecs[0]  = '{1'b0, SIZE_W,  32'h10, 32'h0,        32'h8899AABB, 1'b0, 2, 1, 0};
    vecs[1]  = '{1'b0, SIZE_B,  32'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 1, 0};
    vecs[2]  = '{1'b0, SIZE_BU, 32'h11, 32'h0,        32'h000000AA, 1'b0, 2, 1, 0};
    vecs[3]  = '{1'b0, SIZE_H,  32'h12, 32'h0,        32'hFFFF8899, 1'b0, 2, 1, 0};
    vecs[4]  = '{1'b0, SIZE_HU, 32'h12, 32'h0,        32'h00008899, 1'b0, 2, 1, 0};
    vecs[5]  = '{1'b0, SIZE_B,  32'h13, 32'h0,        32'hFFFFFF88, 1'b0, 2, 1, 0};
    vecs[6]  = '{1'b0, SIZE_H,  32'h10, 32'h0,        32'hFFFFAABB, 1'b0, 2, 1, 0};
    vecs[7]  = '{1'b1, SIZE_B,  32'h12, 32'hFFFFFF55, 32'h0,        1'b0, 4, 1, 1};
    vecs[8]  = '{1'b0, SIZE_W,  32'h10, 32'h0,        32'h8855AABB, 1'b0, 2, 1, 0};
    vecs[9]  = '{1'b1, SIZE_H,  32'h16, 32'h1234ABCD, 32'h0,        1'b0, 4, 1, 1};
    vecs[10] = '{1'b0, SIZE_W,  32'h14, 32'h0,        32'hABCD3344, 1'b0, 2, 1, 0};
    vecs[11] = '{1'b0, SIZE_W,  32'h13, 32'h0,        32'h0,        1'b1, 1, 0, 0};
    vecs[12] = '{1'b1, SIZE_H,  32'h11, 32'hFFFF,     32'h0,        1'b1, 1, 0, 0};
    vecs[13] = '{1'b0, SIZE_HU, 32'h11, 32'h0,        32'h0,        1'b1, 1, 0, 0};
    vecs[14] = '{1'b0, SIZE_W,  32'h10, 32'h0,        32'h8855AABB, 1'b0, 2, 1, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_data_addr", data_addr, 32'h0);
    chk("rst_data_in", data_in, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);

    for (int i = 0; i < 15; i++) run_req(vecs[i], 0);
    chk("misaligned_mem_unchanged", mem[4], 32'h8855AABB);

    // store under backpressure, then read it back
    run_req('{1'b1, SIZE_W, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 3, 0, 1}, 3);
    run_req('{1'b0, SIZE_W, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0}, 0);

`ifdef LSU_ACCESS_CHECK_EN
    run_req('{1'b1, SIZE_W, 32'h1000, 32'hBAD0BAD0, 32'h0, 1'b1, 1, 0, 0}, 0);
    chk("instr_word_protected", mem[11'h400], 32'h12345678);
`else
    run_req('{1'b0, SIZE_W, 32'h1000, 32'h0, 32'h12345678, 1'b0, 2, 1, 0}, 0);
`endif

    // reset during the READ cycle of a byte store
    @(negedge clk);
    wr_cnt    = 0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = SIZE_B;
    req_addr  = 32'h24;
    req_wdata = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    chk("sb_in_read", {31'b0, mem_read}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("midrst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("midrst_mem_write", {31'b0, mem_write}, 32'd0);
    repeat (4) @(negedge clk);
    chk("midrst_no_write", wr_cnt, 32'd0);
    chk("midrst_word_kept", mem[9], 32'hCAFEF00D);
    run_req('{1'b0, SIZE_W, 32'h24, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1, 0}, 0);

    chk("read_write_overlap", both_cnt, 32'd0);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
